// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Issue-stage hazard controller for a 32x32 register file (x0 hardwired
//   to zero). Tracks registers with an in-flight write and stalls issue on
//   RAW or WAW hazards. It also owns the single write port in time: one
//   writeback slot is reserved per cycle, so units with different latencies
//   never collide on the port.
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   iss_valid/rs1/rs2/rd  decode-side instruction presented for issue
//   iss_we, iss_lat       writes rd; cycles from issue to writeback
//   iss_stall, iss_fire   hold decode / instruction accepted this cycle
//   wb_we, wb_addr        register-file write port activity (retirement)
//   wb_due                a writeback is scheduled for this cycle
//   busy_mask, pend_cnt   pending-write bits and their registered popcount
//   sb_err                sticky protocol-violation flag
module reg_scoreboard #(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_LAT = 7,
  parameter int LW      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rs1,
  input  logic [AW-1:0]   iss_rs2,
  input  logic [AW-1:0]   iss_rd,
  input  logic            iss_we,
  input  logic [LW-1:0]   iss_lat,
  output logic            iss_stall,
  output logic            iss_fire,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  output logic            wb_due,
  output logic [NREG-1:0] busy_mask,
  output logic [AW:0]     pend_cnt,
  output logic            sb_err
);

  logic [NREG-1:0]    busy_q, busy_next;
  logic [MAX_LAT-1:0] slots_q, slot_new;
  logic [AW:0]        cnt_next;
  logic [LW-1:0]      lat_eff;
  logic               rd_nz, slot_hit, raw, waw, struct_hz, fire_w, err_now;

  always_comb begin
    lat_eff = iss_lat;
    if (iss_lat == '0)
      lat_eff = LW'(1);
    else if (int'(iss_lat) > MAX_LAT)
      lat_eff = LW'(MAX_LAT);
  end

  // After this cycle's shift, bit L-1 of the next vector is today's bit L.
  // A reservation L == MAX_LAT lands beyond every existing one, so it never
  // conflicts.
  always_comb begin
    slot_hit = 1'b0;
    if (int'(lat_eff) < MAX_LAT)
      slot_hit = slots_q[lat_eff];
  end

  assign rd_nz     = (iss_rd != '0);
  assign raw       = busy_q[iss_rs1] | busy_q[iss_rs2];
  assign waw       = iss_we & rd_nz & busy_q[iss_rd];
  assign struct_hz = iss_we & rd_nz & slot_hit;
  assign iss_stall = iss_valid & (raw | waw | struct_hz);
  assign iss_fire  = iss_valid & ~iss_stall;
  assign fire_w    = iss_fire & iss_we & rd_nz;

  always_comb begin
    slot_new = '0;
    if (fire_w)
      slot_new[lat_eff - LW'(1)] = 1'b1;
  end

  // Set takes priority over clear; WAW guarantees they never hit the same
  // register in one cycle anyway.
  always_comb begin
    busy_next = busy_q;
    if (wb_we)
      busy_next[wb_addr] = 1'b0;
    if (fire_w)
      busy_next[iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREG; i++)
      cnt_next = cnt_next + {{AW{1'b0}}, busy_next[i]};
  end

  assign err_now = (wb_we & ~slots_q[0]) |
                   (slots_q[0] & ~wb_we) |
                   (wb_we & (wb_addr != '0) & ~busy_q[wb_addr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      slots_q  <= '0;
      pend_cnt <= '0;
      sb_err   <= 1'b0;
    end else begin
      busy_q   <= busy_next;
      slots_q  <= (slots_q >> 1) | slot_new;
      pend_cnt <= cnt_next;
      if (err_now)
        sb_err <= 1'b1;
    end
  end

  assign wb_due    = slots_q[0];
  assign busy_mask = busy_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid, iss_we, wb_we;
  logic [4:0]  iss_rs1, iss_rs2, iss_rd, wb_addr;
  logic [2:0]  iss_lat;
  logic        iss_stall, iss_fire, wb_due, sb_err;
  logic [31:0] busy_mask;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  reg_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2),
    .iss_rd(iss_rd), .iss_we(iss_we), .iss_lat(iss_lat),
    .iss_stall(iss_stall), .iss_fire(iss_fire),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_due(wb_due),
    .busy_mask(busy_mask), .pend_cnt(pend_cnt), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_valid = 0; iss_we = 0; iss_rs1 = 0; iss_rs2 = 0; iss_rd = 0; iss_lat = 0;
    wb_we = 0; wb_addr = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic [2:0] lat);
    iss_valid = 1; iss_rs1 = rs1; iss_rs2 = rs2; iss_rd = rd; iss_we = we; iss_lat = lat;
  endtask

  initial begin
    idle();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    #2;
    chk("rst_busy",  busy_mask, 0);
    chk("rst_pend",  pend_cnt, 0);
    chk("rst_stall", iss_stall, 0);
    chk("rst_fire",  iss_fire, 0);
    chk("rst_due",   wb_due, 0);
    chk("rst_err",   sb_err, 0);

    // RAW: x5 lat 3 issued at t, consumer of x5 presented from t+1
    tick(); issue(0, 0, 5, 1, 3); #2;
    chk("raw_t_fire", iss_fire, 1);
    tick(); issue(5, 0, 0, 0, 1); #2;
    chk("raw_t1_stall", iss_stall, 1);
    chk("raw_t1_busy",  busy_mask, 32'h20);
    chk("raw_t1_pend",  pend_cnt, 1);
    chk("raw_t1_due",   wb_due, 0);
    tick(); #2;
    chk("raw_t2_stall", iss_stall, 1);
    chk("raw_t2_due",   wb_due, 0);
    tick(); wb_we = 1; wb_addr = 5; #2;
    chk("raw_t3_due",   wb_due, 1);
    chk("raw_t3_stall", iss_stall, 1);
    tick(); wb_we = 0; wb_addr = 0; #2;
    chk("raw_t4_stall", iss_stall, 0);
    chk("raw_t4_fire",  iss_fire, 1);
    chk("raw_t4_busy",  busy_mask, 0);
    chk("raw_t4_due",   wb_due, 0);
    chk("raw_t4_err",   sb_err, 0);

    // WAW: x7 lat 2, then rd=7 stalls, rd=0 fires, rd=7 fires once retired
    tick(); idle(); issue(0, 0, 7, 1, 2); #2;
    chk("waw_t_fire", iss_fire, 1);
    tick(); issue(0, 0, 7, 1, 2); #2;
    chk("waw_t1_stall", iss_stall, 1);
    tick(); issue(0, 0, 0, 1, 2); wb_we = 1; wb_addr = 7; #2;
    chk("waw_t2_due",   wb_due, 1);
    chk("waw_rd0_fire", iss_fire, 1);
    tick(); wb_we = 0; wb_addr = 0; issue(0, 0, 7, 1, 1); #2;
    chk("waw_t3_busy",  busy_mask, 0);
    chk("waw_t3_fire",  iss_fire, 1);
    tick(); idle(); wb_we = 1; wb_addr = 7; #2;
    chk("waw_t4_due",   wb_due, 1);
    chk("waw_t4_busy",  busy_mask, 32'h80);
    tick(); idle(); #2;
    chk("waw_t5_busy",  busy_mask, 0);
    chk("waw_t5_err",   sb_err, 0);

    // Structural: x3 lat 3, then x4 lat 2 collides, x4 lat 1 fits
    tick(); issue(0, 0, 3, 1, 3); #2;
    chk("st_t_fire", iss_fire, 1);
    tick(); issue(0, 0, 4, 1, 2); #2;
    chk("st_lat2_stall", iss_stall, 1);
    iss_lat = 1; #1;
    chk("st_lat1_fire", iss_fire, 1);
    tick(); idle(); wb_we = 1; wb_addr = 4; #2;
    chk("st_t2_due",  wb_due, 1);
    chk("st_t2_busy", busy_mask, 32'h18);
    chk("st_t2_pend", pend_cnt, 2);
    tick(); wb_we = 1; wb_addr = 3; #2;
    chk("st_t3_due",  wb_due, 1);
    chk("st_t3_busy", busy_mask, 32'h08);
    chk("st_t3_pend", pend_cnt, 1);
    tick(); idle(); #2;
    chk("st_t4_due",  wb_due, 0);
    chk("st_t4_busy", busy_mask, 0);
    chk("st_t4_err",  sb_err, 0);

    // Latency 0 behaves as 1; latency 7 writes back 7 cycles later
    tick(); issue(0, 0, 10, 1, 0); #2;
    chk("lat0_fire", iss_fire, 1);
    tick(); idle(); wb_we = 1; wb_addr = 10; issue(0, 0, 11, 1, 7); #2;
    chk("lat0_due",  wb_due, 1);
    chk("lat7_fire", iss_fire, 1);
    for (int k = 1; k < 7; k++) begin
      tick(); idle(); #2;
      chk("lat7_wait_due", wb_due, 0);
    end
    tick(); wb_we = 1; wb_addr = 11; #2;
    chk("lat7_due", wb_due, 1);
    tick(); idle(); #2;
    chk("lat7_busy", busy_mask, 0);
    chk("lat7_err",  sb_err, 0);

    // Throughput: x1..x8 lat 1 back to back
    for (int k = 0; k <= 9; k++) begin
      tick(); idle();
      if (k < 8) issue(0, 0, 5'(k + 1), 1, 1);
      if (k >= 1 && k <= 8) begin wb_we = 1; wb_addr = 5'(k); end
      #2;
      if (k < 8) chk("tp_stall", iss_stall, 0);
      if (k >= 1 && k <= 8) begin
        chk("tp_due",  wb_due, 1);
        chk("tp_pend", pend_cnt, 1);
        chk("tp_busy", busy_mask, 32'h1 << k);
      end else begin
        chk("tp_due_off", wb_due, 0);
        chk("tp_pend0",   pend_cnt, 0);
      end
    end
    chk("tp_err", sb_err, 0);

    // Protocol error: unscheduled write to non-busy x9, sticky until reset
    tick(); idle(); wb_we = 1; wb_addr = 9; #2;
    chk("pe_err_before", sb_err, 0);
    tick(); idle(); #2;
    chk("pe_err_set",  sb_err, 1);
    chk("pe_busy",     busy_mask, 0);
    tick(); tick(); #2;
    chk("pe_err_held", sb_err, 1);

    // Reset mid-stream with three registers busy
    tick(); issue(0, 0, 12, 1, 5); #2;
    chk("mr_fire12", iss_fire, 1);
    tick(); issue(0, 0, 13, 1, 6); #2;
    chk("mr_fire13", iss_fire, 1);
    tick(); issue(0, 0, 14, 1, 7); #2;
    chk("mr_fire14", iss_fire, 1);
    tick(); idle(); #2;
    chk("mr_busy", busy_mask, 32'h7000);
    chk("mr_pend", pend_cnt, 3);
    rst_n = 0; #1;
    chk("mr_rst_busy",  busy_mask, 0);
    chk("mr_rst_pend",  pend_cnt, 0);
    chk("mr_rst_due",   wb_due, 0);
    chk("mr_rst_err",   sb_err, 0);
    chk("mr_rst_stall", iss_stall, 0);
    tick(); rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      tick(); #2;
      chk("mr_post_due", wb_due, 0);
    end
    chk("mr_post_err", sb_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Issue-stage hazard controller for the 32x32 register file (two async read ports, one clocked write port, x0 hardwired zero).
- Tracks registers with an in-flight write, and stalls issue on RAW and WAW hazards.
- Owns the single register-file write port in time: reserves one writeback slot per cycle, so variable-latency units (ALU, load, multiplier) never collide on the write port.
- Sits between decode and the execute units; writeback retirements are fed back from the write-port driver.

Parameters:
- NREG, 32, number of architectural registers (x0 included).
- AW, 5, register address width.
- MAX_LAT, 7, maximum execute-to-writeback latency in cycles; slot vector width.
- LW, 3, width of the latency field; must satisfy 2^LW > MAX_LAT.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- iss_valid  input  1  decode presents an instruction.
- iss_rs1  input  AW  source register 1.
- iss_rs2  input  AW  source register 2.
- iss_rd  input  AW  destination register.
- iss_we  input  1  instruction writes iss_rd.
- iss_lat  input  LW  cycles from issue to writeback, 1..MAX_LAT.
- iss_stall  output  1  hold decode; instruction not accepted.
- iss_fire  output  1  instruction accepted this cycle (iss_valid & ~iss_stall).
- wb_we  input  1  register-file write enable (WE3) this cycle.
- wb_addr  input  AW  register-file write address (A3) this cycle.
- wb_due  output  1  a writeback is scheduled for this cycle.
- busy_mask  output  NREG  per-register pending-write bits.
- pend_cnt  output  AW+1  popcount of busy_mask.
- sb_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (async, rst_n=0): busy_mask=0, slot vector S=0, sb_err=0, pend_cnt=0, wb_due=0. With iss_valid=0: iss_stall=0, iss_fire=0. Reset mid-operation discards all pending state immediately.
- Effective latency L: L = iss_lat, except 0 is treated as 1 and values above MAX_LAT are clamped to MAX_LAT.
- busy[0] is constant 0. Issue with iss_rd=0 or iss_we=0 sets no busy bit and reserves no slot.
- iss_stall is combinational and equals iss_valid AND any of:
  - RAW: busy[iss_rs1] or busy[iss_rs2];
  - WAW: iss_we & (iss_rd!=0) & busy[iss_rd];
  - structural: iss_we & (iss_rd!=0) & S[L]. Here S[L] is the slot L cycles ahead after this cycle's shift; S[MAX_LAT] reads as 0.
- No same-cycle bypass. A source being retired this cycle (wb_we & wb_addr match) still stalls. The register file writes at the edge, so the read is valid the next cycle.
- Slot vector S[MAX_LAT-1:0]: S[i] means a writeback occurs i cycles from now. wb_due = S[0].
  - Every edge: S <= (S >> 1) | (fire_w ? 1 << (L-1) : 0), where fire_w = iss_fire & iss_we & (iss_rd!=0).
  - Latency 1 means the writeback occurs in the cycle after issue.
- busy[r] update each edge, for r != 0:
  - set if fire_w and iss_rd==r;
  - else clear if wb_we and wb_addr==r;
  - else hold.
  - Set and clear of the same r cannot coincide, because WAW forbids firing while r is busy.
- pend_cnt is registered and equals popcount of the next busy_mask.
- sb_err is set (and held until reset) on any of:
  - wb_we=1 while wb_due=0;
  - wb_due=1 while wb_we=0;
  - wb_we=1 with wb_addr!=0 and busy[wb_addr]=0.
  - The retirement itself is still applied.
- wb_we with wb_addr=0 only affects the sb_err check; it never changes busy.

Test Plan:
- Reset then idle: busy_mask=0, pend_cnt=0, iss_stall=0, wb_due=0, sb_err=0. Assert rst_n low mid-stream with 3 busy registers → all outputs return to 0 within the same cycle.
- RAW: fire rd=5, lat=3 at cycle t; present rs1=5 from t+1. Required: iss_stall=1 through t+3, wb_due=1 at t+3, wb_we/addr=5 driven at t+3, busy[5]=0 and stall=0 at t+4.
- WAW: with x7 busy, present iss_we=1, rd=7, sources free → stall until x7 retires. Same sources with rd=0 → fires immediately.
- Structural: fire rd=3, lat=3 at t; at t+1 present rd=4, lat=2 → stall. At t+1 present rd=4, lat=1 → fires; wb_due at t+2 and t+3.
- Protocol errors: wb_we=1 addr=9 with x9 not busy and wb_due=0 → sb_err=1, sticky until reset.
- Throughput: 8 back-to-back independent lat=1 writes to x1..x8 → no stalls, pend_cnt peaks at 1, wb_due high for 8 consecutive cycles.
